lutram_read_server: RTL and testbench
=====================================

LUTRAM_READ_SERVER -- requirements
Module: lutram_read_server

Interface
REQ-001 Parameter addr_width, default 4: address width in bits.
REQ-002 Parameter data_width, default 8: data width in bits.
REQ-003 Parameter lo, default 0: lowest valid address.
REQ-004 Parameter hi, default 11: highest valid address.
REQ-005 Parameter init_val, default 0 (data_width bits): value written to every entry by the post-reset init sweep.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high.
REQ-007 CLK  in  1  clock; all state updates on the rising edge.
REQ-008 RST  in  1  synchronous reset, active-high.
REQ-009 WR_EN  in  1  write strobe.
REQ-010 WR_ADDR  in  addr_width  write address.
REQ-011 WR_DATA  in  data_width  write data.
REQ-012 RD_REQ_EN  in  1  read-request valid.
REQ-013 RD_REQ_ADDR  in  addr_width  read-request address.
REQ-014 RD_REQ_RDY  out  1  request can be accepted this cycle.
REQ-015 RSP_VALID  out  1  response queue head is valid.
REQ-016 RSP_DATA  out  data_width  response queue head data.
REQ-017 RSP_OOB  out  1  response queue head came from an out-of-range address.
REQ-018 RSP_DEQ  in  1  consumer takes the head this cycle.
REQ-019 INIT_DONE  out  1  init sweep complete.

Function
REQ-020 Storage SHALL be arr[lo:hi] of data_width bits, distributed (LUT) RAM, with an asynchronous read and one synchronous write port.
REQ-021 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT with the sweep pointer at lo.
REQ-022 In INIT, each cycle SHALL write init_val to arr[ptr] and increment ptr; after writing hi, the next state SHALL be RUN, so INIT lasts hi-lo+1 cycles.
REQ-023 In INIT, WR_EN SHALL be ignored, RD_REQ_RDY SHALL be 0, and INIT_DONE SHALL be 0.
REQ-024 In RUN, INIT_DONE SHALL be 1.
REQ-025 In RUN, WR_EN with lo<=WR_ADDR<=hi SHALL write WR_DATA at the clock edge.
REQ-026 A write to an out-of-range WR_ADDR SHALL be dropped with no state change.
REQ-027 The response queue SHALL be a 2-entry FIFO of {oob, data}; count SHALL be 0..2.
REQ-028 RD_REQ_RDY SHALL equal (state==RUN) && (count<2) && !RST.
REQ-029 A request is accepted when RD_REQ_EN && RD_REQ_RDY.
REQ-030 On accept, the block SHALL enqueue arr[RD_REQ_ADDR] with oob=0 if the address is in range, else data=0 with oob=1.
REQ-031 Latency SHALL be 1: RSP_VALID rises in the cycle after accept when the queue was empty.
REQ-032 A write and a read to the same address in the same cycle SHALL return the old data (read-before-write); the new data is visible to requests from the next cycle on.
REQ-033 A dequeue occurs when RSP_DEQ && RSP_VALID; RSP_DEQ with RSP_VALID=0 SHALL be ignored.
REQ-034 A simultaneous accept and dequeue SHALL leave count unchanged and preserve order.
REQ-035 At count=1 with a simultaneous accept and dequeue, the new entry SHALL become the head on the next cycle.
REQ-036 At count=2, requests SHALL be stalled (RD_REQ_RDY=0) until a dequeue; nothing is ever dropped.
REQ-037 RSP_DATA and RSP_OOB SHALL be driven from the head register, not combinationally from RD_REQ_ADDR.
REQ-038 RSP_DATA and RSP_OOB SHALL be held stable while RSP_VALID=1 and RSP_DEQ=0.

Reset
REQ-039 While RST=1, the block SHALL hold state=INIT, ptr=lo, count=0, RSP_VALID=0, RSP_DATA=0, RSP_OOB=0, INIT_DONE=0, and RD_REQ_RDY=0.
REQ-040 Reset mid-operation SHALL discard queued responses.
REQ-041 Reset mid-operation SHALL abort any sweep, which restarts at lo in the first cycle after RST falls.
REQ-042 Writes SHALL be ignored while RST=1.

Verification
REQ-043 Reset, then idle -> INIT_DONE rises exactly 12 cycles after RST falls; reads of addresses 0..11 then return 0x00 with RSP_OOB=0.
REQ-044 Write 0x5A to addr 3, then request addr 3 the next cycle -> RSP_VALID=1 one cycle after accept with RSP_DATA=0x5A. Also: write 0x77 to addr 5 and request addr 5 in the same cycle -> response 0x00, and a later read returns 0x77.
REQ-045 Request addr 14 -> RSP_DATA=0x00, RSP_OOB=1; a write of 0x33 to addr 14 leaves arr[0..11] unchanged.
REQ-046 Hold RSP_DEQ=0 and issue requests to addrs 1, 2, 4 back-to-back -> two are accepted and RD_REQ_RDY=0 on the third; raise RSP_DEQ -> responses arrive in order 1, 2, 4 with none lost.
REQ-047 With count=1, assert RD_REQ_EN and RSP_DEQ every cycle over 8 addresses -> count stays 1 and responses match addresses in order at 1 per cycle.
REQ-048 Assert RST for one cycle at sweep pointer 6 with one response queued -> queue is empty, RSP_VALID=0, and INIT_DONE rises 12 cycles after RST falls.

Source files
------------

// File: rtl/lutram_read_server.sv
// LUT-RAM with a post-reset init sweep and a 2-deep
// read-response queue (1-cycle latency, read-before-write).
module lutram_read_server #(
  parameter int addr_width = 4,
  parameter int data_width = 8,
  parameter int lo = 0,
  parameter int hi = 11,
  parameter logic [data_width-1:0] init_val = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [addr_width-1:0] WR_ADDR,
  input  logic [data_width-1:0] WR_DATA,
  input  logic                  RD_REQ_EN,
  input  logic [addr_width-1:0] RD_REQ_ADDR,
  output logic                  RD_REQ_RDY,
  output logic                  RSP_VALID,
  output logic [data_width-1:0] RSP_DATA,
  output logic                  RSP_OOB,
  input  logic                  RSP_DEQ,
  output logic                  INIT_DONE
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q, ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [data_width-1:0] hd_q, hd_d;
  logic [data_width-1:0] tl_q, tl_d;
  logic                  ho_q, ho_d;
  logic                  to_q, to_d;
  logic                  done_q, done_d;

  logic [data_width-1:0] arr [lo:hi];

  function automatic logic in_rng(
    input logic [addr_width-1:0] a
  );
    int v;
    v = int'(a);
    return (v >= lo) && (v <= hi);
  endfunction

  logic                  rd_in;
  logic                  wr_in;
  logic [data_width-1:0] rd_data;
  logic                  acc;
  logic                  deq;

  assign rd_in   = in_rng(RD_REQ_ADDR);
  assign wr_in   = in_rng(WR_ADDR);
  assign rd_data = rd_in ? arr[RD_REQ_ADDR] : '0;

  assign RD_REQ_RDY = (state_q == RUN) &&
                      (cnt_q != 2'd2) && !RST;
  assign acc = RD_REQ_EN && RD_REQ_RDY;
  assign deq = RSP_DEQ && (cnt_q != 2'd0);

  assign RSP_VALID = (cnt_q != 2'd0);
  assign RSP_DATA  = hd_q;
  assign RSP_OOB   = ho_q;
  assign INIT_DONE = done_q;

  // Async read happens before the edge, so same-cycle
  // writes are only seen by later requests.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_q == INIT)
        arr[ptr_q] <= init_val;
      else if (WR_EN && wr_in)
        arr[WR_ADDR] <= WR_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    hd_d    = hd_q;
    ho_d    = ho_q;
    tl_d    = tl_q;
    to_d    = to_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + addr_width'(1);
      if (int'(ptr_q) == hi) begin
        state_d = RUN;
        done_d  = 1'b1;
      end
    end
    if (acc && deq) begin
      if (cnt_q == 2'd1) begin
        hd_d = rd_data;
        ho_d = !rd_in;
      end else begin
        hd_d = tl_q;
        ho_d = to_q;
        tl_d = rd_data;
        to_d = !rd_in;
      end
    end else if (acc) begin
      if (cnt_q == 2'd0) begin
        hd_d = rd_data;
        ho_d = !rd_in;
      end else begin
        tl_d = rd_data;
        to_d = !rd_in;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (deq) begin
      hd_d  = tl_q;
      ho_d  = to_q;
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      ptr_q   <= addr_width'(lo);
      cnt_q   <= 2'd0;
      hd_q    <= '0;
      ho_q    <= 1'b0;
      tl_q    <= '0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hd_q    <= hd_d;
      ho_q    <= ho_d;
      tl_q    <= tl_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lutram_read_server.sv
// Bench for lutram_read_server: directed table, corner
// sequences and random traffic against a queue model.
module tb_lutram_read_server;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LO = 0;
  localparam int HI = 11;

  logic          CLK = 1'b0;
  logic          RST;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          RD_REQ_EN;
  logic [AW-1:0] RD_REQ_ADDR;
  logic          RD_REQ_RDY;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_OOB;
  logic          RSP_DEQ;
  logic          INIT_DONE;

  always #5 CLK = ~CLK;

  lutram_read_server #(
    .addr_width(AW), .data_width(DW),
    .lo(LO), .hi(HI), .init_val(8'h00)
  ) dut (
    .CLK(CLK), .RST(RST),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .RD_REQ_EN(RD_REQ_EN),
    .RD_REQ_ADDR(RD_REQ_ADDR),
    .RD_REQ_RDY(RD_REQ_RDY),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .RSP_OOB(RSP_OOB), .RSP_DEQ(RSP_DEQ),
    .INIT_DONE(INIT_DONE)
  );

  typedef struct packed {
    logic          oob;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          dq;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eo;
  } vec_t;

  rsp_t          mq[$];
  logic [DW-1:0] mm [0:15];
  logic [DW-1:0] popped[$];
  bit            m_run;
  int            m_cnt;
  bit            m_lastrst;
  int            n_chk;
  int            n_fail;
  logic          s_rdy;
  logic [DW-1:0] s_data;
  vec_t          tbl [6];

  function automatic bit inr(input logic [AW-1:0] a);
    return int'(a) >= LO && int'(a) <= HI;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drv(input logic we,
                     input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd,
                     input logic re,
                     input logic [AW-1:0] ra,
                     input logic dq);
    WR_EN = we; WR_ADDR = wa; WR_DATA = wd;
    RD_REQ_EN = re; RD_REQ_ADDR = ra; RSP_DEQ = dq;
  endtask

  task automatic step();
    @(negedge CLK);
    s_rdy  = RD_REQ_RDY;
    s_data = RSP_DATA;
    chk("rdy", 32'(RD_REQ_RDY),
        32'(m_run && mq.size() < 2 && !RST));
    chk("valid", 32'(RSP_VALID), 32'(mq.size() != 0));
    chk("init_done", 32'(INIT_DONE), 32'(m_run));
    if (mq.size() != 0) begin
      chk("data", 32'(RSP_DATA), 32'(mq[0].data));
      chk("oob", 32'(RSP_OOB), 32'(mq[0].oob));
    end else if (m_lastrst) begin
      chk("rst_data", 32'(RSP_DATA), 32'h0);
      chk("rst_oob", 32'(RSP_OOB), 32'h0);
    end
    @(posedge CLK);
    m_lastrst = RST;
    if (RST) begin
      mq.delete();
      m_run = 0;
      m_cnt = 0;
    end else if (!m_run) begin
      mm[LO + m_cnt] = 8'h00;
      m_cnt++;
      if (m_cnt == HI - LO + 1) m_run = 1;
    end else begin
      bit   acc;
      bit   dq;
      rsp_t r;
      acc = RD_REQ_EN && mq.size() < 2;
      dq  = RSP_DEQ && mq.size() != 0;
      if (inr(RD_REQ_ADDR)) begin
        r.oob = 1'b0; r.data = mm[RD_REQ_ADDR];
      end else begin
        r.oob = 1'b1; r.data = 8'h00;
      end
      if (dq) begin
        popped.push_back(s_data);
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(r);
      if (WR_EN && inr(WR_ADDR)) mm[WR_ADDR] = WR_DATA;
    end
    #1;
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!INIT_DONE && n < 50) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'd12);
  endtask

  initial begin
    int g;
    n_chk = 0; n_fail = 0;
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    RST = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    m_lastrst = 1; m_run = 0; m_cnt = 0;
    step(); step();
    chk("rst_rdy", 32'(s_rdy), 32'h0);

    RST = 1'b0;
    wait_init("init_cycles");
    for (int a = 0; a < 12; a++) begin
      drv(0, 0, 0, 1, AW'(a), 1);
      step();
      chk("init_val", 32'(RSP_DATA), 32'h0);
      chk("init_oob", 32'(RSP_OOB), 32'h0);
    end
    drv(0, 0, 0, 0, 0, 1);
    step(); step();

    tbl[0] = '{1, 3, 8'h5A, 0, 0, 0, 0, 8'h00, 0};
    tbl[1] = '{0, 0, 8'h00, 1, 3, 0, 1, 8'h5A, 0};
    tbl[2] = '{1, 5, 8'h77, 1, 5, 1, 1, 8'h00, 0};
    tbl[3] = '{0, 0, 8'h00, 1, 5, 1, 1, 8'h77, 0};
    tbl[4] = '{0, 0, 8'h00, 1, 14, 1, 1, 8'h00, 1};
    tbl[5] = '{1, 14, 8'h33, 0, 0, 1, 0, 8'h00, 0};
    for (int i = 0; i < 6; i++) begin
      drv(tbl[i].we, tbl[i].wa, tbl[i].wd,
          tbl[i].re, tbl[i].ra, tbl[i].dq);
      step();
      chk($sformatf("tbl%0d_valid", i),
          32'(RSP_VALID), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i),
            32'(RSP_DATA), 32'(tbl[i].ed));
        chk($sformatf("tbl%0d_oob", i),
            32'(RSP_OOB), 32'(tbl[i].eo));
      end
    end
    for (int a = 0; a < 12; a++) begin
      drv(0, 0, 0, 1, AW'(a), 1);
      step();
    end
    drv(0, 0, 0, 0, 0, 1);
    step(); step();

    drv(1, 1, 8'h11, 0, 0, 0); step();
    drv(1, 2, 8'h22, 0, 0, 0); step();
    drv(1, 4, 8'h44, 0, 0, 0); step();
    popped.delete();
    drv(0, 0, 0, 1, 1, 0); step();
    drv(0, 0, 0, 1, 2, 0); step();
    drv(0, 0, 0, 1, 4, 0); step();
    chk("stall_rdy", 32'(s_rdy), 32'h0);
    drv(0, 0, 0, 1, 4, 1);
    g = 0;
    do begin
      step();
      g++;
    end while (!s_rdy && g < 10);
    chk("stall_accept", 32'(s_rdy), 32'h1);
    drv(0, 0, 0, 0, 0, 1);
    g = 0;
    while (popped.size() < 3 && g < 10) begin
      step();
      g++;
    end
    chk("order_cnt", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("order0", 32'(popped[0]), 32'h11);
      chk("order1", 32'(popped[1]), 32'h22);
      chk("order2", 32'(popped[2]), 32'h44);
    end

    drv(0, 0, 0, 1, 0, 0); step();
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 1, AW'(i), 1);
      step();
      chk("c1_valid", 32'(RSP_VALID), 32'h1);
      chk("c1_rdy", 32'(s_rdy), 32'h1);
    end
    drv(0, 0, 0, 0, 0, 1);
    step(); step();

    drv(0, 0, 0, 1, 7, 0); step();
    drv(1, 2, 8'h99, 0, 0, 0);
    RST = 1'b1; step();
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(RSP_VALID), 32'h0);
    repeat (6) step();
    RST = 1'b1; step();
    RST = 1'b0;
    chk("rst2_valid", 32'(RSP_VALID), 32'h0);
    wait_init("reinit_cycles");
    for (int a = 0; a < 12; a++) begin
      drv(0, 0, 0, 1, AW'(a), 1);
      step();
    end

    for (int i = 0; i < 800; i++) begin
      RST = ($urandom_range(0, 249) == 0);
      drv($urandom_range(0, 1) == 1,
          AW'($urandom_range(0, 15)),
          DW'($urandom),
          $urandom_range(0, 1) == 1,
          AW'($urandom_range(0, 15)),
          $urandom_range(0, 9) < 6);
      step();
    end
    RST = 1'b0;
    drv(0, 0, 0, 0, 0, 1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
